// File: rtl/mch_tx_pkg.sv
// Shared constants, FSM encoding and latched-frame type for the Manchester TX path.
package mch_tx_pkg;

  localparam logic [7:0] MCH_SYNC   = 8'hD5;
  localparam int         MCH_MAX_PD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_LEN,
    S_DATA
  } state_t;

  typedef struct packed {
    logic [7:0]                  len;
    logic [2:0]                  n;
    logic [MCH_MAX_PD-1:0][7:0]  pd;
  } frame_t;

  // Payload bytes actually sent: length clamped to MCH_MAX_PD.
  function automatic logic [2:0] pd_count(input logic [7:0] len);
    return (len > 8'(MCH_MAX_PD)) ? 3'(MCH_MAX_PD) : len[2:0];
  endfunction

endpackage

// File: rtl/mch_tx_tick.sv
// Half-bit tick generator: tick pulses in the last cycle of every HALF_DIV-cycle half-bit.
module mch_tx_tick #(
  parameter int HALF_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(HALF_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(HALF_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else if (en)           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mch_tx.sv
// Manchester frame transmitter: PRE, SYNC, LEN, payload; MSB first, '1' = low->high.
module mch_tx
  import mch_tx_pkg::*;
#(
  parameter int HALF_DIV = 25,
  parameter int PRE_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] length,
  input  logic [7:0] pd0,
  input  logic [7:0] pd1,
  input  logic [7:0] pd2,
  input  logic [7:0] pd3,
  output logic       txsd,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(PRE_BITS);

  state_t          state, state_nxt;
  frame_t          frm;
  logic [7:0]      sh, sh_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [1:0]      byte_idx, byte_nxt;
  logic [PW-1:0]   pre_cnt, pre_nxt;
  logic            phase, phase_nxt;
  logic            txsd_nxt, done_nxt;
  logic            tick, accept, bit_end;

  assign busy    = (state != S_IDLE);
  assign accept  = start && !busy;
  assign bit_end = tick && phase;

  mch_tx_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    pre_nxt   = pre_cnt;
    phase_nxt = phase;
    txsd_nxt  = txsd;
    done_nxt  = 1'b0;
    if (state == S_IDLE) begin
      if (accept) begin
        state_nxt = S_PRE;
        pre_nxt   = '0;
        phase_nxt = 1'b0;
        txsd_nxt  = 1'b0;  // first half of the leading preamble '1'
      end
    end else if (tick && !phase) begin
      phase_nxt = 1'b1;
      txsd_nxt  = (state == S_PRE) ? ~pre_cnt[0] : sh[7];
    end else if (bit_end) begin
      phase_nxt = 1'b0;
      bit_nxt   = bit_idx + 3'd1;
      sh_nxt    = {sh[6:0], 1'b0};
      case (state)
        S_PRE:
          if (pre_cnt == PW'(PRE_BITS - 1)) begin
            state_nxt = S_SYNC;
            sh_nxt    = MCH_SYNC;
            bit_nxt   = '0;
          end else begin
            pre_nxt = pre_cnt + 1'b1;
          end
        S_SYNC:
          if (bit_idx == 3'd7) begin
            state_nxt = S_LEN;
            sh_nxt    = frm.len;
          end
        S_LEN:
          if (bit_idx == 3'd7) begin
            if (frm.n == 3'd0) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DATA;
              sh_nxt    = frm.pd[0];
              byte_nxt  = '0;
            end
          end
        S_DATA:
          if (bit_idx == 3'd7) begin
            if ({1'b0, byte_idx} == frm.n - 3'd1) begin
              state_nxt = S_IDLE;
            end else begin
              byte_nxt = byte_idx + 2'd1;
              sh_nxt   = frm.pd[byte_idx + 2'd1];
            end
          end
        default: ;
      endcase
      // Line either returns to idle or starts the first half of the next bit.
      if (state_nxt == S_IDLE) begin
        txsd_nxt = 1'b1;
        done_nxt = 1'b1;
      end else begin
        txsd_nxt = (state_nxt == S_PRE) ? pre_nxt[0] : ~sh_nxt[7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sh       <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      pre_cnt  <= '0;
      phase    <= 1'b0;
      txsd     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh       <= sh_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      pre_cnt  <= pre_nxt;
      phase    <= phase_nxt;
      txsd     <= txsd_nxt;
      done     <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        frm <= '0;
    else if (accept) frm <= '{len: length, n: pd_count(length), pd: {pd3, pd2, pd1, pd0}};
  end

endmodule

// File: tb/tb_mch_tx.sv
// Frame-level bench: decodes txsd mid-half-bit and compares against a queued expectation.
module tb_mch_tx;

  localparam int H  = 25;
  localparam int PB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] length = '0, pd0 = '0, pd1 = '0, pd2 = '0, pd3 = '0;
  logic       txsd, busy, done;

  mch_tx #(.HALF_DIV(H), .PRE_BITS(PB)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .pd0(pd0), .pd1(pd1), .pd2(pd2), .pd3(pd3),
    .txsd(txsd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] nbytes;
    logic [47:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, ndone = 0, ndone_exp = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called right after a negedge; start is seen by the following posedge.
  task automatic send(input logic [7:0] len, input logic [7:0] b0, b1, b2, b3, input bit push);
    exp_t e;
    length = len; pd0 = b0; pd1 = b1; pd2 = b2; pd3 = b3;
    start  = 1'b1;
    if (push) begin
      e.nbytes = 32'(2 + ((len > 8'd4) ? 4 : int'(len)));
      e.data   = {8'hD5, len, b0, b1, b2, b3};
      sb.push_back(e);
      ndone_exp++;
    end
    @(negedge clk);
    start  = 1'b0;
    length = 8'($urandom); pd0 = 8'($urandom); pd1 = 8'($urandom);
    pd2 = 8'($urandom); pd3 = 8'($urandom);
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", {47'd0, done}, 48'd1);
  endtask

  // Monitor / decoder
  bit          in_frame = 0, prev_busy = 0;
  int          p = 0, nb = 0, errs = 0;
  logic        hv = 1'b1, first = 1'b1;
  logic [15:0] gpre = '0;
  logic [47:0] gdata = '0;

  always @(negedge clk) begin
    exp_t        e;
    logic [47:0] al;
    int          o, h;
    if (!rst) begin
      in_frame  = 0;
      prev_busy = 0;
    end else begin
      if (done) ndone++;
      if (busy && !prev_busy) begin
        in_frame = 1; p = 0; nb = 0; errs = 0; gpre = '0; gdata = '0;
      end
      if (in_frame && busy) begin
        o = p % H;
        h = p / H;
        if (o == 0) hv = txsd;
        else if (txsd !== hv) errs++;
        if (o == H / 2) begin
          if (h % 2 == 0) first = txsd;
          else begin
            if (first === txsd) errs++;
            if (nb < PB) gpre = {gpre[14:0], txsd};
            else         gdata = {gdata[46:0], txsd};
            nb++;
          end
        end
        p++;
      end
      if (!busy && prev_busy && in_frame) begin
        in_frame = 0;
        chk("frame_expected", {47'd0, sb.size() > 0}, 48'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("busy_cycles", 48'(p), 48'((PB + 8 * int'(e.nbytes)) * 2 * H));
          chk("nbits", 48'(nb), 48'(PB + 8 * int'(e.nbytes)));
          chk("preamble", {32'd0, gpre}, 48'hAAAA);
          chk("halfbit_errs", 48'(errs), 48'd0);
          al = (nb - PB > 0 && nb - PB <= 48) ? (gdata << (48 - (nb - PB))) : gdata;
          for (int i = 0; i < int'(e.nbytes); i++)
            chk($sformatf("byte%0d", i), {40'd0, al[47 - 8 * i -: 8]}, {40'd0, e.data[47 - 8 * i -: 8]});
        end
        chk("done_at_end", {47'd0, done}, 48'd1);
        chk("txsd_idle_at_end", {47'd0, txsd}, 48'd1);
      end
      prev_busy = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txsd", {47'd0, txsd}, 48'd1);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_done", {47'd0, done}, 48'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two payload bytes
    send(8'd2, 8'h12, 8'h34, 8'h00, 8'h00, 1);
    wait_done(4000);
    repeat (3) @(negedge clk);

    // 2: empty payload
    send(8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
    wait_done(4000);
    repeat (3) @(negedge clk);

    // 3: oversized length clamps payload to four bytes
    send(8'd9, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1);
    wait_done(4000);
    repeat (3) @(negedge clk);

    // 4: restarts while busy are ignored
    send(8'd3, 8'h5A, 8'hC3, 8'h0F, 8'h77, 1);
    repeat (98) @(negedge clk);
    send(8'd1, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    repeat (898) @(negedge clk);
    send(8'd4, 8'h99, 8'h88, 8'h77, 8'h66, 0);
    wait_done(4000);
    repeat (10) @(negedge clk);
    chk("no_queued_frame", {47'd0, busy}, 48'd0);

    // 5: asynchronous abort mid-frame
    send(8'd2, 8'hDE, 8'hAD, 8'h00, 8'h00, 0);
    repeat (699) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {47'd0, busy}, 48'd0);
    chk("abort_txsd", {47'd0, txsd}, 48'd1);
    chk("abort_done", {47'd0, done}, 48'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_abort_busy", {47'd0, busy}, 48'd0);
    send(8'd2, 8'hBE, 8'hEF, 8'h00, 8'h00, 1);
    wait_done(4000);

    // 6: back-to-back, second start in the done cycle
    send(8'd1, 8'h3C, 8'h00, 8'h00, 8'h00, 1);
    wait_done(4000);
    send(8'd2, 8'h81, 8'h7E, 8'h00, 8'h00, 1);
    @(negedge clk);
    chk("b2b_busy_next", {47'd0, busy}, 48'd1);
    wait_done(4000);
    repeat (5) @(negedge clk);

    chk("final_busy", {47'd0, busy}, 48'd0);
    chk("final_txsd", {47'd0, txsd}, 48'd1);
    chk("done_count", 48'(ndone), 48'(ndone_exp));
    chk("sb_drained", 48'(sb.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
